// File: rtl/imem_fetch.sv
// imem_fetch: PC/fetch sequencer for a combinational 8-bit instruction memory with a {pc, instr} prefetch FIFO
//   i_clk            system clock, all state on the rising edge
//   i_clear          asynchronous active-low reset
//   i_start          begin fetching from START_ADDR (pulse, honoured in IDLE/DONE)
//   o_mem_addr       instruction memory address (the pc itself)
//   i_mem_instr      instruction returned by memory in the same cycle
//   i_redirect_valid load i_redirect_addr into pc and flush the FIFO (FETCH/DRAIN only)
//   i_redirect_addr  redirect target
//   o_out_valid      FIFO head valid
//   i_out_ready      decode accepts the head this cycle
//   o_out_instr      instruction at the FIFO head
//   o_out_pc         address of the instruction at the FIFO head
//   o_busy           high in FETCH or DRAIN
//   o_done           high in DONE
//   o_fetch_count    instructions pushed since the last start (wraps)
module imem_fetch #(
  parameter int START_ADDR = 0,
  parameter int PROG_LEN   = 11,
  parameter int DEPTH      = 4
) (
  input  logic       i_clk,
  input  logic       i_clear,
  input  logic       i_start,
  output logic [7:0] o_mem_addr,
  input  logic [7:0] i_mem_instr,
  input  logic       i_redirect_valid,
  input  logic [7:0] i_redirect_addr,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [7:0] o_out_instr,
  output logic [7:0] o_out_pc,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_fetch_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t          r_state;
  logic [7:0]      r_pc;
  logic [7:0]      r_fetch_count;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_instr [DEPTH];
  logic [7:0]      r_pcs   [DEPTH];
  logic            w_redir;
  logic            w_pop;
  logic            w_push;
  logic            w_pc_ok;
  assign w_pc_ok = r_pc < 8'(PROG_LEN);
  // Redirect outranks both handshakes: the flush discards any pop and blocks the push.
  assign w_redir = i_redirect_valid & (r_state == FETCH || r_state == DRAIN);
  assign w_pop   = o_out_valid & i_out_ready & ~w_redir;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push  = (r_state == FETCH) & w_pc_ok & ~w_redir & (r_count != CW'(DEPTH) | w_pop);
  assign o_mem_addr    = r_pc;
  assign o_out_valid   = r_count != '0;
  assign o_out_instr   = o_out_valid ? r_instr[r_rd] : '0;
  assign o_out_pc      = o_out_valid ? r_pcs[r_rd] : '0;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_fetch_count = r_fetch_count;
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_instr[r_wr] <= i_mem_instr;
      r_pcs[r_wr]   <= r_pc;
    end
  end
  always_ff @(posedge i_clk or negedge i_clear) begin
    if (!i_clear) begin
      r_state       <= IDLE;
      r_pc          <= '0;
      r_fetch_count <= '0;
      r_count       <= '0;
      r_rd          <= '0;
      r_wr          <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else if (w_redir) begin
      r_state <= FETCH;
      r_pc    <= i_redirect_addr;
      r_count <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      if (w_push) begin
        r_pc          <= r_pc + 8'd1;
        r_wr          <= r_wr + AW'(1);
        r_fetch_count <= r_fetch_count + 8'd1;
      end
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state       <= FETCH;
            r_pc          <= 8'(START_ADDR);
            r_fetch_count <= '0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
          end
        end
        FETCH: begin
          if (!w_pc_ok)
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (r_count == '0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: directed vector table plus hand sequences for imem_fetch against an 11-word program
module tb_imem_fetch;
  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_instr;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_addr = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic       busy;
  logic       done;
  logic [7:0] fetch_count;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] rom [16] = '{8'h49, 8'h61, 8'h45, 8'h07, 8'h79, 8'h2C, 8'hA2, 8'h0D,
                           8'h7B, 8'h1E, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  typedef struct {
    logic       start;
    logic       rdy;
    logic       ev;
    logic [7:0] epc;
    logic [7:0] einstr;
    logic [7:0] emem;
    logic       ebusy;
    logic       edone;
    logic [7:0] efc;
  } vec_t;
  vec_t vt [14];

  always #5 clk = ~clk;
  always_comb mem_instr = (mem_addr < 8'd11) ? rom[mem_addr[3:0]] : 8'h00;

  imem_fetch dut (
    .i_clk(clk), .i_clear(clear), .i_start(start), .o_mem_addr(mem_addr),
    .i_mem_instr(mem_instr), .i_redirect_valid(redirect_valid), .i_redirect_addr(redirect_addr),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_instr(out_instr), .o_out_pc(out_pc),
    .o_busy(busy), .o_done(done), .o_fetch_count(fetch_count)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [7:0] epc, input logic [7:0] einstr,
                         input logic [7:0] emem, input logic ebusy, input logic edone, input logic [7:0] efc);
    chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ev});
    if (ev) begin
      chk({tag, ".out_pc"}, out_pc, epc);
      chk({tag, ".out_instr"}, out_instr, einstr);
    end
    chk({tag, ".mem_addr"}, mem_addr, emem);
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, ebusy});
    chk({tag, ".done"}, {7'd0, done}, {7'd0, edone});
    chk({tag, ".fetch_count"}, fetch_count, efc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int n);
    for (int i = 0; i < n && !done; i++) tick();
    chk({tag, ".done_reached"}, {7'd0, done}, 8'd1);
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'h00, 8'd0, 1'b1, 1'b0, 8'd0};
    for (int n = 1; n <= 11; n++)
      vt[n] = '{1'b0, 1'b1, 1'b1, 8'(n - 1), rom[n - 1], 8'(n), 1'b1, 1'b0, 8'(n)};
    vt[12] = '{1'b0, 1'b1, 1'b0, 8'd0, 8'h00, 8'd11, 1'b1, 1'b0, 8'd11};
    vt[13] = '{1'b0, 1'b1, 1'b0, 8'd0, 8'h00, 8'd11, 1'b0, 1'b1, 8'd11};

    #1 clear = 1'b0;
    #1;
    chk_out("reset", 1'b0, 8'd0, 8'h00, 8'd0, 1'b0, 1'b0, 8'd0);
    chk("reset.out_pc", out_pc, 8'd0);
    chk("reset.out_instr", out_instr, 8'h00);
    #10 clear = 1'b1;

    for (int i = 0; i < 14; i++) begin
      start = vt[i].start;
      out_ready = vt[i].rdy;
      tick();
      chk_out($sformatf("stream[%0d]", i), vt[i].ev, vt[i].epc, vt[i].einstr, vt[i].emem,
              vt[i].ebusy, vt[i].edone, vt[i].efc);
    end

    out_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    chk_out("stall_full", 1'b1, 8'd0, 8'h49, 8'd4, 1'b1, 1'b0, 8'd4);
    out_ready = 1'b1; tick();
    chk_out("stall_pushpop", 1'b1, 8'd1, 8'h61, 8'd5, 1'b1, 1'b0, 8'd5);
    out_ready = 1'b0; tick();
    chk_out("stall_still_full", 1'b1, 8'd1, 8'h61, 8'd5, 1'b1, 1'b0, 8'd5);
    out_ready = 1'b1;
    wait_done("stall", 30);
    chk_out("stall_end", 1'b0, 8'd0, 8'h00, 8'd11, 1'b0, 1'b1, 8'd11);

    start = 1'b1; tick(); start = 1'b0;
    chk_out("redir_start", 1'b0, 8'd0, 8'h00, 8'd0, 1'b1, 1'b0, 8'd0);
    repeat (3) tick();
    chk_out("redir_head2", 1'b1, 8'd2, 8'h45, 8'd3, 1'b1, 1'b0, 8'd3);
    redirect_valid = 1'b1; redirect_addr = 8'd9; tick(); redirect_valid = 1'b0;
    chk_out("redir_flush", 1'b0, 8'd0, 8'h00, 8'd9, 1'b1, 1'b0, 8'd3);
    tick();
    chk_out("redir_pc9", 1'b1, 8'd9, 8'h1E, 8'd10, 1'b1, 1'b0, 8'd4);
    tick();
    chk_out("redir_pc10", 1'b1, 8'd10, 8'hC3, 8'd11, 1'b1, 1'b0, 8'd5);
    tick();
    chk_out("redir_drain", 1'b0, 8'd0, 8'h00, 8'd11, 1'b1, 1'b0, 8'd5);
    tick();
    chk_out("redir_done", 1'b0, 8'd0, 8'h00, 8'd11, 1'b0, 1'b1, 8'd5);

    start = 1'b1; tick(); start = 1'b0;
    redirect_valid = 1'b1; redirect_addr = 8'd200; tick(); redirect_valid = 1'b0;
    chk_out("far_redir", 1'b0, 8'd0, 8'h00, 8'd200, 1'b1, 1'b0, 8'd0);
    tick();
    chk_out("far_drain", 1'b0, 8'd0, 8'h00, 8'd200, 1'b1, 1'b0, 8'd0);
    tick();
    chk_out("far_done", 1'b0, 8'd0, 8'h00, 8'd200, 1'b0, 1'b1, 8'd0);

    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    chk_out("busy_head3", 1'b1, 8'd3, 8'h07, 8'd4, 1'b1, 1'b0, 8'd4);
    start = 1'b1; tick(); start = 1'b0;
    chk_out("busy_start_ignored", 1'b1, 8'd4, 8'h79, 8'd5, 1'b1, 1'b0, 8'd5);

    out_ready = 1'b0;
    repeat (2) tick();
    chk_out("clr_buffered", 1'b1, 8'd4, 8'h79, 8'd7, 1'b1, 1'b0, 8'd7);
    clear = 1'b0;
    #1;
    chk_out("clr_async", 1'b0, 8'd0, 8'h00, 8'd0, 1'b0, 1'b0, 8'd0);
    #2 clear = 1'b1;
    tick();
    chk_out("clr_idle", 1'b0, 8'd0, 8'h00, 8'd0, 1'b0, 1'b0, 8'd0);
    out_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    tick();
    chk_out("clr_restart", 1'b1, 8'd0, 8'h49, 8'd1, 1'b1, 1'b0, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_fetch.md
Name: imem_fetch

Overview:
Instruction fetch unit and reader side of the 8-bit combinational instruction memory. It holds the program counter and drives the memory address. It samples the returned instruction the same cycle and buffers {pc, instruction} pairs in a small prefetch FIFO. A valid/ready handshake presents these pairs to the decode stage, and a redirect port lets execute steer fetch on jumps/branches.

Parameters:
START_ADDR, 0, PC loaded on start
PROG_LEN, 11, number of valid memory words; fetch stops when pc reaches it (legal 1..255)
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, all state on rising edge
clear  input  1  asynchronous active-low reset
start  input  1  begin fetch from START_ADDR (pulse)
mem_addr  output  8  address to instruction memory, equals pc combinationally
mem_instr  input  8  instruction word returned by memory, same cycle
redirect_valid  input  1  load new pc and flush FIFO
redirect_addr  input  8  target pc for redirect
out_valid  output  1  FIFO head valid
out_ready  input  1  decode accepts head this cycle
out_instr  output  8  instruction at FIFO head
out_pc  output  8  address of instruction at FIFO head
busy  output  1  high in FETCH or DRAIN
done  output  1  high in DONE
fetch_count  output  8  instructions pushed since last start

Behaviour:
- Reset (clear=0, async): state=IDLE, pc=0, FIFO empty, fetch_count=0. Outputs: out_valid=0, busy=0, done=0, mem_addr=0, out_instr=0, out_pc=0.
- mem_addr = pc at all times; no address register beyond pc.
- FIFO: out_valid = count!=0. out_instr/out_pc come from head storage, with no combinational path from mem_instr. Pop = out_valid & out_ready.
- Push condition: state==FETCH, pc<PROG_LEN, and (count<DEPTH or pop this cycle). Push writes {pc, mem_instr}, pc<=pc+1, fetch_count+=1 (wraps at 256).
- Simultaneous push and pop on a full FIFO: both occur and count is unchanged. On an empty FIFO the pushed entry is visible the next cycle, with no bypass.
- States:
  IDLE: on start -> FETCH, pc<=START_ADDR, fetch_count<=0. Other inputs ignored.
  FETCH: push per rule. If pc>=PROG_LEN (no push) -> DRAIN.
  DRAIN: no pushes; -> DONE when count==0.
  DONE: done=1. On start -> FETCH as from IDLE (FIFO already empty).
- Redirect (FETCH or DRAIN only; ignored in IDLE/DONE): FIFO flushed (count=0), pc<=redirect_addr, state<=FETCH.
  - Redirect has priority over push and pop that cycle: no push, and any pop handshake that cycle is discarded.
  - fetch_count is not cleared.
  - redirect_addr>=PROG_LEN -> FETCH then DRAIN next cycle, then DONE.
- start while busy: ignored. start and redirect together while busy: redirect wins.
- Latency: start sampled at edge k; first push at edge k+1; out_valid=1 after edge k+1, carrying START_ADDR. With out_ready held 1, one instruction per cycle thereafter.
- Full-FIFO stall: pc holds, mem_addr stable, no push until space.
- Async clear mid-fetch: immediate return to reset values; the buffered instruction is lost.

Test Plan:
- Reset then start with out_ready=1 over the 11-word program -> out stream pc 0..10 with instr 0x49,0x61,0x45,0x07,0x79,0x2C,0xA2,0x0D,0x7B,0x1E,0xC3 on consecutive cycles; then DRAIN->DONE, done=1, fetch_count=11, busy=0.
- Start with out_ready=0 -> 4 pushes, out_valid=1, pc holds at 4 and mem_addr=4; raise out_ready -> pc 0 (0x49) popped, pc 4 (0x79) pushed the same cycle, count stays 4.
- Redirect to 9 on the cycle pc 2 is accepted -> that pop discarded, FIFO empty next cycle; then pc 9 (0x1E), pc 10 (0xC3), DONE; fetch_count=3+2=5.
- Redirect with redirect_addr=200 during FETCH -> no pushes, DRAIN then DONE within 2 cycles, out_valid=0 throughout.
- Assert clear mid-fetch with 3 entries buffered -> out_valid=0, mem_addr=0, done=0 immediately. start after release -> stream restarts at pc 0 with 0x49.
- start pulsed while busy -> ignored. start in DONE -> restart from pc 0 and fetch_count reset to 0.
